// File: rtl/neuron_mac.sv
// neuron_mac: streaming single-neuron multiply-accumulate with bias, rescale, saturation and optional ReLU.
// Weights come from an external memory with a registered read port (data valid the cycle after w_ren).
module neuron_mac #(
    parameter int NUM_WEIGHT = 30,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 10,
    parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  w_ren,
    output logic [ADDR_WIDTH-1:0] w_radd,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_valid
);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(NUM_WEIGHT);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          count_q, count_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]   x_q, x_d;
    logic                           mac_en_q, mac_en_d;
    logic [DATA_WIDTH-1:0]          y_q, y_d;
    logic                           y_valid_q, y_valid_d;
    logic                           accept, last;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W:0]          s, r;
    logic [DATA_WIDTH-1:0]          sat, res;

    always_comb begin
        x_ready   = state_q == ACCUM;
        accept    = x_valid && x_ready;
        last      = accept && count_q == ADDR_WIDTH'(NUM_WEIGHT - 1);
        w_ren     = accept;
        w_radd    = count_q;
        state_d   = (state_q == IDLE || state_q == OUTPUT) ? ACCUM :
                    state_q == DRAIN ? OUTPUT : last ? DRAIN : ACCUM;
        prod      = x_q * $signed(w_rdata);
        // Rescale from Q(2*FRAC) to Q(FRAC); the extra bit keeps acc+bias from wrapping
        s         = (ACC_W+1)'(acc_q) + ((ACC_W+1)'($signed(bias)) <<< FRAC_BITS);
        r         = s >>> FRAC_BITS;
        sat       = r > MAXV ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                    r < MINV ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : r[DATA_WIDTH-1:0];
        res       = (RELU != 0 && r[ACC_W]) ? '0 : sat;
        count_d   = state_q == OUTPUT ? '0 : accept ? count_q + 1'b1 : count_q;
        acc_d     = state_q == OUTPUT ? '0 : mac_en_q ? acc_q + ACC_W'(prod) : acc_q;
        x_d       = accept ? $signed(x_in) : x_q;
        mac_en_d  = accept;
        y_d       = state_q == OUTPUT ? res : y_q;
        y_valid_d = state_q == OUTPUT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            mac_en_q  <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            mac_en_q  <= mac_en_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y_out   = y_q;
    assign y_valid = y_valid_q;
endmodule
